// File: rtl/row_buffer_pkg.sv
// Shared types and helpers for the ping-pong row buffer.
package row_buffer_pkg;

  typedef enum logic {
    RB_IDLE  = 1'b0,
    RB_CLEAR = 1'b1
  } rb_state_t;

  localparam int unsigned RB_MAX_WORD_W = 256;

  // Replicates one pixel value across ppw lanes of pix_bits each (pix_bits < 32).
  function automatic logic [RB_MAX_WORD_W-1:0] rb_replicate(
    input logic [31:0] pix,
    input int unsigned pix_bits,
    input int unsigned ppw
  );
    logic [RB_MAX_WORD_W-1:0] w;
    logic [31:0]              lane;
    w    = '0;
    lane = pix & ((32'd1 << pix_bits) - 32'd1);
    for (int unsigned i = 0; i < ppw; i++) begin
      w = w | ({{(RB_MAX_WORD_W-32){1'b0}}, lane} << (i * pix_bits));
    end
    return w;
  endfunction

endpackage

// File: rtl/row_buffer_pingpong_if.sv
// Draw/display-side bus of the ping-pong row buffer.
interface row_buffer_pingpong_if #(
  parameter int unsigned PIXEL_BITS      = 4,
  parameter int unsigned PIXELS_PER_WORD = 4,
  parameter int unsigned WORDS           = 256,
  parameter int unsigned ADDR_W          = $clog2(WORDS)
);
  localparam int unsigned DATA_W = PIXEL_BITS * PIXELS_PER_WORD;

  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic [PIXELS_PER_WORD-1:0] wr_mask;
  logic                       wr_ready;
  logic [ADDR_W-1:0]          rd_addr;
  logic [DATA_W-1:0]          rd_data;
  logic                       swap_req;
  logic                       swap_ack;
  logic                       front_bank;
  logic                       busy;

  modport master (
    output wr_en, wr_addr, wr_data, wr_mask, rd_addr, swap_req,
    input  wr_ready, rd_data, swap_ack, front_bank, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_mask, rd_addr, swap_req,
    output wr_ready, rd_data, swap_ack, front_bank, busy
  );
endinterface

// File: rtl/row_buffer_pingpong_bank.sv
// One row bank: masked synchronous write port, registered read port, no reset on storage.
module row_bank #(
  parameter int unsigned PIXEL_BITS      = 4,
  parameter int unsigned PIXELS_PER_WORD = 4,
  parameter int unsigned WORDS           = 256,
  parameter int unsigned ADDR_W          = $clog2(WORDS)
) (
  input  logic                                  i_clk,
  input  logic                                  i_we,
  input  logic [ADDR_W-1:0]                     i_waddr,
  input  logic [PIXELS_PER_WORD-1:0]            i_wmask,
  input  logic [PIXEL_BITS*PIXELS_PER_WORD-1:0] i_wdata,
  input  logic                                  i_re,
  input  logic [ADDR_W-1:0]                     i_raddr,
  output logic [PIXEL_BITS*PIXELS_PER_WORD-1:0] o_rdata
);

  // One narrow memory per pixel lane so each mask bit is a plain lane write enable.
  for (genvar p = 0; p < PIXELS_PER_WORD; p++) begin : g_lane
    logic [PIXEL_BITS-1:0] r_mem [WORDS];
    logic [PIXEL_BITS-1:0] r_rd;

    always_ff @(posedge i_clk) begin
      if (i_we && i_wmask[p]) begin
        r_mem[i_waddr] <= i_wdata[p*PIXEL_BITS +: PIXEL_BITS];
      end
      if (i_re) begin
        r_rd <= r_mem[i_raddr];
      end
    end

    assign o_rdata[p*PIXEL_BITS +: PIXEL_BITS] = r_rd;
  end

endmodule

// File: rtl/row_buffer_pingpong.sv
// Double-buffered row memory with swap handshake.
// ROW_BUFFER_CLEAR_EN builds the clear engine that fills the new back bank after each swap.
module row_buffer_pingpong
  import row_buffer_pkg::*;
#(
  parameter int unsigned PIXEL_BITS      = 4,
  parameter int unsigned PIXELS_PER_WORD = 4,
  parameter int unsigned WORDS           = 256,
  parameter int unsigned ADDR_W          = $clog2(WORDS),
  parameter int unsigned CLEAR_VALUE     = 0
) (
  input  logic            Clk,
  input  logic            Reset_n,
  row_buffer_pingpong_if.slave bus
);

  localparam int unsigned DATA_W = PIXEL_BITS * PIXELS_PER_WORD;
  localparam logic [RB_MAX_WORD_W-1:0] CLEAR_FULL =
    rb_replicate(32'(CLEAR_VALUE), PIXEL_BITS, PIXELS_PER_WORD);
  localparam logic [DATA_W-1:0] CLEAR_WORD = CLEAR_FULL[DATA_W-1:0];
  localparam logic [ADDR_W:0]   WORDS_LIM  = (ADDR_W+1)'(WORDS);

  rb_state_t r_state, w_state_nxt;
  logic      r_front;
  logic      r_ack;
  logic      r_rd_sel;
  logic      r_rd_valid;
  logic      w_swap;
  logic      w_clearing;
  logic      w_wr_in_range;
  logic      w_rd_in_range;
  logic      w_draw_we;
  logic      w_we;
  logic [ADDR_W-1:0]          w_clr_addr;
  logic [ADDR_W-1:0]          w_waddr;
  logic [DATA_W-1:0]          w_wdata;
  logic [PIXELS_PER_WORD-1:0] w_wmask;
  logic [DATA_W-1:0]          w_bank_rd [2];

`ifdef ROW_BUFFER_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= RB_IDLE;
      r_front    <= 1'b0;
      r_ack      <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ack      <= w_swap;
      if (w_swap) begin
        r_front <= ~r_front;
      end
      r_rd_sel   <= r_front;
      r_rd_valid <= w_rd_in_range;
    end
  end

`ifdef ROW_BUFFER_CLEAR_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
  assign w_clr_addr = r_cnt;
`else
  assign w_clr_addr = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_swap      = 1'b0;
`ifdef ROW_BUFFER_CLEAR_EN
    w_cnt_nxt   = r_cnt;
`endif
    unique case (r_state)
      RB_IDLE: begin
        if (bus.swap_req) begin
          w_swap = 1'b1;
`ifdef ROW_BUFFER_CLEAR_EN
          w_state_nxt = RB_CLEAR;
          w_cnt_nxt   = '0;
`endif
        end
      end
      RB_CLEAR: begin
`ifdef ROW_BUFFER_CLEAR_EN
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == LAST_ADDR) begin
          w_state_nxt = RB_IDLE;
          w_cnt_nxt   = '0;
        end
`else
        w_state_nxt = RB_IDLE;
`endif
      end
    endcase
  end

  assign w_clearing    = (r_state == RB_CLEAR);
  assign w_wr_in_range = ({1'b0, bus.wr_addr} < WORDS_LIM);
  assign w_rd_in_range = ({1'b0, bus.rd_addr} < WORDS_LIM);
  assign w_draw_we     = bus.wr_en && !w_clearing && w_wr_in_range && (|bus.wr_mask);

  // The clear engine borrows the single write port while it runs.
  assign w_we    = w_clearing | w_draw_we;
  assign w_waddr = w_clearing ? w_clr_addr : bus.wr_addr;
  assign w_wdata = w_clearing ? CLEAR_WORD : bus.wr_data;
  assign w_wmask = w_clearing ? '1 : bus.wr_mask;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    row_bank #(
      .PIXEL_BITS      (PIXEL_BITS),
      .PIXELS_PER_WORD (PIXELS_PER_WORD),
      .WORDS           (WORDS),
      .ADDR_W          (ADDR_W)
    ) u_bank (
      .i_clk   (Clk),
      .i_we    (w_we && (r_front != 1'(b))),
      .i_waddr (w_waddr),
      .i_wmask (w_wmask),
      .i_wdata (w_wdata),
      .i_re    (w_rd_in_range && (r_front == 1'(b))),
      .i_raddr (bus.rd_addr),
      .o_rdata (w_bank_rd[b])
    );
  end

  // Bank read registers carry no reset; the valid flag forces 0 after reset and out of range.
  assign bus.rd_data    = r_rd_valid ? (r_rd_sel ? w_bank_rd[1] : w_bank_rd[0]) : '0;
  assign bus.swap_ack   = r_ack;
  assign bus.front_bank = r_front;
`ifdef ROW_BUFFER_CLEAR_EN
  assign bus.busy       = w_clearing;
  assign bus.wr_ready   = ~w_clearing;
`else
  assign bus.busy       = 1'b0;
  assign bus.wr_ready   = 1'b1;
`endif

endmodule
